perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_pkg.sv | 23 ++
 rtl/perf_counter_ch.sv | 86 ++++++++
 rtl/perf_counter_bank.sv | 106 ++++++++++
 tb/tb_perf_counter_bank.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter bank.
//   mode_e       : per-channel counting mode encoding
//   DEF_NUM_CH   : default number of event channels
//   DEF_CNT_W    : default counter width
//   ch_sel_w()   : width of a channel-select field for a given channel count
package perf_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_CYCLE = 2'b01,
    MODE_LEVEL = 2'b10,
    MODE_EDGE  = 2'b11
  } mode_e;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CNT_W  = 32;

  // A single channel still needs a 1-bit select so the port never collapses to zero width.
  function automatic int unsigned ch_sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_ch.sv
// One event-counter channel: mode register, counter, previous-event sample and
// sticky overflow flag.
//   clk, reset : clock and synchronous active-high reset
//   halt       : freezes counting (previous-event sample still updates)
//   event_in   : this channel's event line
//   cfg_sel    : configuration write addressed to this channel
//   cfg_mode   : mode to load on cfg_sel
//   cfg_clear  : with cfg_sel, zero the counter and overflow flag
//   count      : live counter value
//   ovf        : sticky overflow flag
module perf_counter_ch
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             event_in,
  input  logic             cfg_sel,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_clear,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q, prev_d;
  logic             ovf_q, ovf_d;
  logic             inc;

  always_comb begin
    inc = 1'b0;
    if (!halt) begin
      unique case (mode_q)
        MODE_CYCLE: inc = 1'b1;
        MODE_LEVEL: inc = event_in;
        MODE_EDGE:  inc = event_in && !prev_q;
        default:    inc = 1'b0;
      endcase
    end
  end

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    // The edge detector tracks the line regardless of mode or halt.
    prev_d = event_in;
    if (cfg_sel) begin
      // A configuration write suppresses this channel's increment for the edge.
      mode_d = mode_e'(cfg_mode);
      if (cfg_clear) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_OFF;
      cnt_q  <= '0;
      prev_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
      ovf_q  <= ovf_d;
    end
  end

  assign count = cnt_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with shadow snapshot, registered shadow read
// port and a free-running cycle counter.
//   clk, reset        : clock and synchronous active-high reset
//   events            : one event line per channel
//   halt              : freezes all counting (config, snap and read still work)
//   cfg_we/ch/mode/clear : per-channel configuration write
//   snap              : copy live counters into the shadow registers
//   rd_en, rd_ch      : shadow read request
//   rd_data, rd_valid : registered read response (one cycle latency)
//   ovf               : sticky per-channel overflow flags
//   cycle_count       : wrapping cycle counter, frozen by halt
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned SATURATE = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             events,
  input  logic                          halt,
  input  logic                          cfg_we,
  input  logic [ch_sel_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [1:0]                    cfg_mode,
  input  logic                          cfg_clear,
  input  logic                          snap,
  input  logic                          rd_en,
  input  logic [ch_sel_w(NUM_CH)-1:0]   rd_ch,
  output logic [CNT_W-1:0]              rd_data,
  output logic                          rd_valid,
  output logic [NUM_CH-1:0]             ovf,
  output logic [CNT_W-1:0]              cycle_count
);

  localparam int unsigned CH_W = ch_sel_w(NUM_CH);

  logic [CNT_W-1:0] live_cnt [NUM_CH];
  logic [CNT_W-1:0] shadow_q [NUM_CH];
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic cfg_sel;
    // An out-of-range cfg_ch matches no generated index, so it is dropped here.
    assign cfg_sel = cfg_we && (cfg_ch == CH_W'(i));

    perf_counter_ch #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .halt      (halt),
      .event_in  (events[i]),
      .cfg_sel   (cfg_sel),
      .cfg_mode  (cfg_mode),
      .cfg_clear (cfg_clear),
      .count     (live_cnt[i]),
      .ovf       (ovf[i])
    );
  end

  // Loop mux so an out-of-range rd_ch falls through to zero without indexing past the array.
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_sel = shadow_q[i];
      end
    end
  end

  always_comb begin
    cycle_d   = halt ? cycle_q : cycle_q + CNT_W'(1);
    rd_data_d = rd_en ? rd_sel : rd_data_q;
  end

  // Shadow is read before it is written, so a same-edge snap+read returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
      end
      cycle_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (snap) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          shadow_q[i] <= live_cnt[i];
        end
      end
      cycle_q    <= cycle_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign cycle_count = cycle_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           reset, halt, cfg_we, cfg_clear, snap, rd_en;
  logic [NCH-1:0] events;
  logic [CHW-1:0] cfg_ch, rd_ch;
  logic [1:0]     cfg_mode;

  logic [W-1:0]   w_rd_data, w_cycle, s_rd_data, s_cycle;
  logic           w_rd_valid, s_rd_valid;
  logic [NCH-1:0] w_ovf, s_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Wrapping instance
  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(W), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .events(events), .halt(halt), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_clear(cfg_clear), .snap(snap),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(w_rd_data), .rd_valid(w_rd_valid),
    .ovf(w_ovf), .cycle_count(w_cycle)
  );

  // Saturating instance, same stimulus
  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(W), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .events(events), .halt(halt), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_clear(cfg_clear), .snap(snap),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .ovf(s_ovf), .cycle_count(s_cycle)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic [1:0] m, input logic clr);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_mode = m; cfg_clear = clr;
    step();
    cfg_we = 1'b0; cfg_clear = 1'b0;
  endtask

  // Snapshot then read one channel; response is visible on return.
  task automatic read_ch(input int ch);
    snap = 1'b1;
    step();
    snap = 1'b0; rd_en = 1'b1; rd_ch = CHW'(ch);
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (w_cycle !== 8'd0) begin n_err++; $display("FAIL reset_cycle: got %0d want 0", w_cycle); end
    n_cmp++; if (w_ovf !== 3'b000) begin n_err++; $display("FAIL reset_ovf: got %b want 000", w_ovf); end
    n_cmp++; if (w_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", w_rd_valid); end
    n_cmp++; if (w_rd_data !== 8'd0) begin n_err++; $display("FAIL reset_rd_data: got %0d want 0", w_rd_data); end
    halt = 1'b0;
    repeat (10) step();
    n_cmp++; if (w_cycle !== 8'd10) begin n_err++; $display("FAIL cycle_10: got %0d want 10", w_cycle); end
    n_cmp++; if (s_cycle !== 8'd10) begin n_err++; $display("FAIL cycle_10_sat: got %0d want 10", s_cycle); end
    n_cmp++; if (w_ovf !== 3'b000) begin n_err++; $display("FAIL idle_ovf: got %b want 000", w_ovf); end
    halt = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      read_ch(c);
      n_cmp++; if (w_rd_data !== 8'd0) begin n_err++; $display("FAIL idle_count ch%0d: got %0d want 0", c, w_rd_data); end
    end
  endtask

  task automatic test_edge_mode();
    int seq [5] = '{0, 1, 1, 0, 1};
    halt = 1'b0; events = '0;
    do_reset();
    cfg(1, MODE_EDGE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      events[1] = seq[i][0];
      step();
    end
    events = '0; halt = 1'b1;
    read_ch(1);
    n_cmp++; if (w_rd_data !== 8'd2) begin n_err++; $display("FAIL edge_count: got %0d want 2", w_rd_data); end
    n_cmp++; if (w_rd_valid !== 1'b1) begin n_err++; $display("FAIL edge_rd_valid: got %b want 1", w_rd_valid); end
    step();
    n_cmp++; if (w_rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_pulse: got %b want 0", w_rd_valid); end
    n_cmp++; if (w_rd_data !== 8'd2) begin n_err++; $display("FAIL rd_data_hold: got %0d want 2", w_rd_data); end
  endtask

  task automatic test_wrap_saturate();
    halt = 1'b0; events = '0;
    do_reset();
    cfg(0, MODE_CYCLE, 1'b0);
    repeat (257) step();
    halt = 1'b1;
    n_cmp++; if (w_ovf !== 3'b001) begin n_err++; $display("FAIL wrap_ovf: got %b want 001", w_ovf); end
    n_cmp++; if (s_ovf !== 3'b001) begin n_err++; $display("FAIL sat_ovf: got %b want 001", s_ovf); end
    // reset edge -> 0, cfg edge -> 1, then 257 more -> 258 mod 256
    n_cmp++; if (w_cycle !== 8'd2) begin n_err++; $display("FAIL cycle_wrap: got %0d want 2", w_cycle); end
    n_cmp++; if (s_cycle !== 8'd2) begin n_err++; $display("FAIL cycle_wrap_sat: got %0d want 2", s_cycle); end
    read_ch(0);
    n_cmp++; if (w_rd_data !== 8'd1) begin n_err++; $display("FAIL wrap_count: got %0d want 1", w_rd_data); end
    n_cmp++; if (s_rd_data !== 8'd255) begin n_err++; $display("FAIL sat_count: got %0d want 255", s_rd_data); end
  endtask

  task automatic test_halt();
    halt = 1'b0; events = '0;
    do_reset();
    cfg(0, MODE_CYCLE, 1'b0);   // ch0 skips this edge
    cfg(1, MODE_EDGE, 1'b0);    // ch0 counts on this edge -> 1
    repeat (3) step();          // ch0 = 4, cycle = 5
    halt = 1'b1; events[1] = 1'b1;
    repeat (5) step();
    n_cmp++; if (w_cycle !== 8'd5) begin n_err++; $display("FAIL halt_cycle: got %0d want 5", w_cycle); end
    read_ch(0);
    n_cmp++; if (w_rd_data !== 8'd4) begin n_err++; $display("FAIL halt_count: got %0d want 4", w_rd_data); end
    n_cmp++; if (w_cycle !== 8'd5) begin n_err++; $display("FAIL halt_cycle_rd: got %0d want 5", w_cycle); end
    halt = 1'b0;
    repeat (2) step();          // events[1] rose while halted: no edge seen now
    halt = 1'b1;
    read_ch(0);
    n_cmp++; if (w_rd_data !== 8'd6) begin n_err++; $display("FAIL resume_count: got %0d want 6", w_rd_data); end
    read_ch(1);
    n_cmp++; if (w_rd_data !== 8'd0) begin n_err++; $display("FAIL halt_prev_sample: got %0d want 0", w_rd_data); end
    events = '0;
  endtask

  task automatic test_clear();
    halt = 1'b0; events = '0;
    do_reset();
    events[2] = 1'b1;
    cfg(2, MODE_LEVEL, 1'b0);
    repeat (258) step();
    n_cmp++; if (w_ovf !== 3'b100) begin n_err++; $display("FAIL clear_pre_ovf: got %b want 100", w_ovf); end
    cfg(2, MODE_LEVEL, 1'b1);
    n_cmp++; if (w_ovf !== 3'b000) begin n_err++; $display("FAIL clear_ovf: got %b want 000", w_ovf); end
    n_cmp++; if (s_ovf !== 3'b000) begin n_err++; $display("FAIL clear_ovf_sat: got %b want 000", s_ovf); end
    halt = 1'b1;
    read_ch(2);
    n_cmp++; if (w_rd_data !== 8'd0) begin n_err++; $display("FAIL clear_count: got %0d want 0", w_rd_data); end
    n_cmp++; if (s_rd_data !== 8'd0) begin n_err++; $display("FAIL clear_count_sat: got %0d want 0", s_rd_data); end
    events = '0;
  endtask

  task automatic test_back_to_back();
    halt = 1'b0; events = '0;
    do_reset();
    cfg(0, MODE_CYCLE, 1'b0);
    repeat (4) step();          // ch0 = 4
    halt = 1'b1; snap = 1'b1;
    step();
    snap = 1'b0; halt = 1'b0;
    repeat (3) step();          // ch0 = 7, shadow = 4
    halt = 1'b1;
    snap = 1'b1; rd_en = 1'b1; rd_ch = 2'd0;
    step();
    snap = 1'b0;
    n_cmp++; if (w_rd_data !== 8'd4) begin n_err++; $display("FAIL snap_rd_same_edge: got %0d want 4", w_rd_data); end
    step();                     // rd_en held for a second request
    rd_en = 1'b0;
    n_cmp++; if (w_rd_data !== 8'd7) begin n_err++; $display("FAIL b2b_rd_data: got %0d want 7", w_rd_data); end
    n_cmp++; if (w_rd_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rd_valid: got %b want 1", w_rd_valid); end
    step();
    n_cmp++; if (w_rd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop: got %b want 0", w_rd_valid); end
  endtask

  // Continues from test_back_to_back: ch0 = 7 in mode cycle, halted.
  task automatic test_out_of_range();
    rd_en = 1'b1; rd_ch = 2'd3;
    step();
    rd_en = 1'b0;
    n_cmp++; if (w_rd_valid !== 1'b1) begin n_err++; $display("FAIL oor_rd_valid: got %b want 1", w_rd_valid); end
    n_cmp++; if (w_rd_data !== 8'd0) begin n_err++; $display("FAIL oor_rd_data: got %0d want 0", w_rd_data); end
    cfg(3, MODE_CYCLE, 1'b1);
    read_ch(0);
    n_cmp++; if (w_rd_data !== 8'd7) begin n_err++; $display("FAIL oor_cfg_clear: got %0d want 7", w_rd_data); end
    halt = 1'b0;
    repeat (2) step();
    halt = 1'b1;
    read_ch(0);
    n_cmp++; if (w_rd_data !== 8'd9) begin n_err++; $display("FAIL oor_ch0_mode: got %0d want 9", w_rd_data); end
    for (int c = 1; c < NCH; c++) begin
      read_ch(c);
      n_cmp++; if (w_rd_data !== 8'd0) begin n_err++; $display("FAIL oor_mode_alias ch%0d: got %0d want 0", c, w_rd_data); end
    end
  endtask

  task automatic test_reset_mid();
    halt = 1'b0; events = '0;
    cfg(1, MODE_LEVEL, 1'b0);
    events[1] = 1'b1;
    repeat (5) step();
    reset = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = MODE_CYCLE;
    snap = 1'b1; rd_en = 1'b1; rd_ch = 2'd0; events = '1;
    step();
    reset = 1'b0; cfg_we = 1'b0; snap = 1'b0; rd_en = 1'b0; events = '0;
    n_cmp++; if (w_cycle !== 8'd0) begin n_err++; $display("FAIL midrst_cycle: got %0d want 0", w_cycle); end
    n_cmp++; if (w_rd_valid !== 1'b0) begin n_err++; $display("FAIL midrst_rd_valid: got %b want 0", w_rd_valid); end
    n_cmp++; if (w_rd_data !== 8'd0) begin n_err++; $display("FAIL midrst_rd_data: got %0d want 0", w_rd_data); end
    repeat (3) step();          // all modes off after reset
    halt = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      read_ch(c);
      n_cmp++; if (w_rd_data !== 8'd0) begin n_err++; $display("FAIL midrst_count ch%0d: got %0d want 0", c, w_rd_data); end
    end
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; cfg_we = 1'b0; cfg_clear = 1'b0; snap = 1'b0;
    rd_en = 1'b0; events = '0; cfg_ch = '0; rd_ch = '0; cfg_mode = 2'b00;
    step();
    test_reset();
    test_edge_mode();
    test_wrap_saturate();
    test_halt();
    test_clear();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
